// File: rtl/sys_init_seq_if.sv
// Bring-up bus between the init sequencer (master) and the MCU/subsystems (slave).
interface sys_init_seq_if #(
  parameter int N_STAGES = 4
);
  logic                START;
  logic [N_STAGES-1:0] STAGE_DONE;
  logic [N_STAGES-1:0] STAGE_REQ;
  logic [N_STAGES-1:0] STAGE_EN;
  logic                READY;
  logic                ERROR;
  logic [2:0]          ERR_STAGE;

  modport master (
    input  START, STAGE_DONE,
    output STAGE_REQ, STAGE_EN, READY, ERROR, ERR_STAGE
  );

  modport slave (
    output START, STAGE_DONE,
    input  STAGE_REQ, STAGE_EN, READY, ERROR, ERR_STAGE
  );
endinterface

// File: rtl/sys_init_seq.sv
// Power-up sequencer: settle, then per-stage request/done bring-up with timeout; registered outputs.
// Optional SYS_INIT_AUTO_START_EN: leave IDLE on the first edge out of reset without START.
module sys_init_seq #(
  parameter int N_STAGES      = 4,
  parameter int SETTLE_CYCLES = 1024,
  parameter int STAGE_TIMEOUT = 65535,
  parameter int CNT_W         = 16
) (
  input  logic           SYS_CLK,
  input  logic           S_RST_N,
  sys_init_seq_if.master bus
);

  generate
    if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_stages
      $error("sys_init_seq: N_STAGES must be 1..8");
    end
    if (SETTLE_CYCLES < 1 || STAGE_TIMEOUT < 2) begin : g_bad_times
      $error("sys_init_seq: SETTLE_CYCLES >= 1 and STAGE_TIMEOUT >= 2 required");
    end
    if ((SETTLE_CYCLES - 1) >= (1 << CNT_W) || (STAGE_TIMEOUT - 1) >= (1 << CNT_W)) begin : g_bad_cnt
      $error("sys_init_seq: CNT_W too narrow");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STAGE_TIMEOUT - 1);
  localparam logic [2:0]       LAST_STAGE   = 3'(N_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    REQ    = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          idx, idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [N_STAGES-1:0] req, req_nxt;
  logic [N_STAGES-1:0] en, en_nxt;
  logic                ready, ready_nxt;
  logic                error, error_nxt;
  logic [2:0]          err_stage, err_stage_nxt;
  logic                done_cur;
  logic                go;

  // Only the done bit of the stage currently being requested matters.
  always_comb begin
    done_cur = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (idx == 3'(i)) done_cur = bus.STAGE_DONE[i];
    end
  end

`ifdef SYS_INIT_AUTO_START_EN
  assign go = 1'b1;
`else
  assign go = bus.START;
`endif

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    req_nxt       = req;
    en_nxt        = en;
    ready_nxt     = ready;
    error_nxt     = error;
    err_stage_nxt = err_stage;

    unique case (state)
      IDLE: begin
        if (go) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end

      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = REQ;
          idx_nxt   = 3'd0;
          req_nxt   = N_STAGES'(1);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      REQ: begin
        // Done takes priority over a coincident timeout.
        if (done_cur) begin
          en_nxt  = en | (N_STAGES'(1) << idx);
          cnt_nxt = '0;
          if (idx == LAST_STAGE) begin
            state_nxt = DONE;
            req_nxt   = '0;
            ready_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
            req_nxt = N_STAGES'(1) << (idx + 3'd1);
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt     = FAULT;
          req_nxt       = '0;
          en_nxt        = '0;
          error_nxt     = 1'b1;
          err_stage_nxt = idx;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE, FAULT: begin
        if (bus.START) begin
          state_nxt     = SETTLE;
          cnt_nxt       = '0;
          en_nxt        = '0;
          ready_nxt     = 1'b0;
          error_nxt     = 1'b0;
          err_stage_nxt = 3'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
        req_nxt   = '0;
        en_nxt    = '0;
        ready_nxt = 1'b0;
        error_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!S_RST_N) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= '0;
      req       <= '0;
      en        <= '0;
      ready     <= 1'b0;
      error     <= 1'b0;
      err_stage <= 3'd0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      req       <= req_nxt;
      en        <= en_nxt;
      ready     <= ready_nxt;
      error     <= error_nxt;
      err_stage <= err_stage_nxt;
    end
  end

  assign bus.STAGE_REQ = req;
  assign bus.STAGE_EN  = en;
  assign bus.READY     = ready;
  assign bus.ERROR     = error;
  assign bus.ERR_STAGE = err_stage;

endmodule

// File: doc/sys_init_seq.md
# sys_init_seq

Power-up initialisation sequencer in the SYS_CLK domain. Sits directly downstream of the per-domain reset generator, which supplies the synchronous reset. After reset it waits a settle interval, then brings up N_STAGES subsystems in fixed order (DAC/ADC front-end, MAC, DMT modulator, ...) with a per-stage request/done handshake and timeout. It produces cumulative enables and a single READY/ERROR status for the MCU.

## Interface
- N_STAGES, 4, number of sequenced subsystems (1..8)
- SETTLE_CYCLES, 1024, post-reset settle interval in SYS_CLK cycles (≥1)
- STAGE_TIMEOUT, 65535, max cycles to wait for a stage's done (≥2)
- CNT_W, 16, counter width; must hold max(SETTLE_CYCLES, STAGE_TIMEOUT)

Ports:
- SYS_CLK  in  1  system clock; all logic on rising edge
- S_RST_N  in  1  reset, synchronous, active-low
- START  in  1  single-cycle pulse; starts or restarts the sequence
- STAGE_DONE  in  N_STAGES  per-stage completion level from each subsystem
- STAGE_REQ  out  N_STAGES  one-hot bring-up request, held until done or timeout
- STAGE_EN  out  N_STAGES  thermometer of completed stages (bit i = stage i up)
- READY  out  1  all stages up
- ERROR  out  1  sequence aborted on timeout
- ERR_STAGE  out  3  index of the stage that timed out

## Operation
- States: IDLE, SETTLE, REQ, DONE, FAULT.
- Reset (S_RST_N=0 at an edge): state IDLE, stage index 0, counter 0. All outputs are 0.
- IDLE:
  - START=1 → SETTLE, counter cleared.
  - Also see Configuration (auto-start).
- SETTLE:
  - Counter increments each cycle.
  - When counter = SETTLE_CYCLES-1 → REQ with index 0. STAGE_REQ[0] is set on the same edge and the counter is cleared.
- REQ:
  - STAGE_DONE[index] is sampled each cycle.
  - On done: STAGE_EN[index] is set, STAGE_REQ[index] is cleared, and the counter is cleared, all on the same edge.
    - If index = N_STAGES-1 → DONE with READY=1.
    - Otherwise the index increments and STAGE_REQ[index+1] is set on that same edge. There is no gap cycle.
  - On counter = STAGE_TIMEOUT-1 without done → FAULT. ERROR=1, ERR_STAGE=index, STAGE_REQ=0, STAGE_EN=0.
  - If done and timeout occur in the same cycle, done wins.
- DONE/FAULT: held indefinitely. START=1 clears READY, ERROR, ERR_STAGE and STAGE_EN, then goes to SETTLE.
- START is ignored in SETTLE and REQ.
- STAGE_DONE bits other than the current index are ignored in all states.
- A STAGE_DONE level already high when a request begins is accepted on the first REQ cycle.
- Counter saturates rather than wraps; it never exceeds STAGE_TIMEOUT-1.
- Reset asserted mid-sequence returns to IDLE with all outputs 0 on that edge.

## Timing
- Latency from START edge to STAGE_REQ[0] high: SETTLE_CYCLES+1 edges.
- Stage handshake:
  - STAGE_REQ[i] rises at edge k.
  - The earliest accepted done is sampled at edge k+1, so minimum request width is 1 cycle.
  - STAGE_EN[i] rises, and STAGE_REQ[i] falls, at the edge that samples done.
- Best-case total sequence from START to READY: SETTLE_CYCLES+1+N_STAGES cycles.
- Timeout: FAULT is entered STAGE_TIMEOUT cycles after STAGE_REQ[i] rose.
- All outputs are registered; no combinational path from input to output.

## Configuration
- SYS_INIT_AUTO_START_EN defined:
  - On the first edge with S_RST_N=1 after reset, IDLE goes to SETTLE without START.
  - IDLE is entered only via reset.
- Undefined: IDLE waits for START indefinitely.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use N_STAGES=3, SETTLE_CYCLES=8, STAGE_TIMEOUT=16, macro undefined unless noted.
- Nominal run:
  - Stimulus: START pulse; each done raised 2 cycles after its request.
  - Response: REQ[0] at edge 9; STAGE_EN steps 001→011→111; READY=1 at edge 18.
- Timeout:
  - Stimulus: stage 1 never completes.
  - Response: ERROR=1 and ERR_STAGE=1 exactly 16 cycles after REQ[1] rose; STAGE_EN=000; STAGE_REQ=000.
- Pre-asserted done:
  - Stimulus: all STAGE_DONE tied high.
  - Response: READY 8+1+3=12 edges after START; each REQ bit is high for exactly 1 cycle.
- Restart and ignore:
  - Stimulus: START during REQ; then START in FAULT.
  - Response: START in REQ is ignored; START in FAULT clears ERROR and reruns the sequence to READY.
- Mid-run reset:
  - Stimulus: S_RST_N=0 for 1 cycle while in REQ of stage 2.
  - Response: all outputs 0 at that edge; with done tied high, no REQ reappears without a new START.
- Auto-start (SYS_INIT_AUTO_START_EN defined):
  - Stimulus: release reset, no START.
  - Response: REQ[0] rises 9 edges after release.
